mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares the single unified memory port between the instruction-fetch requester (read-only) and the load/store requester. One transaction is outstanding at a time. Data has fixed priority, with a starvation limit that guarantees fetch progress. Sits between the core's IF/MEM stages and the memory.

Parameters:
ADDR_W, 32, address width
STARVE_LIMIT, 4, consecutive data grants tolerated while fetch waits (legal 1..15)
TIMEOUT_CYCLES, 64, response watchdog limit (used only with ARB_TIMEOUT_EN)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
if_req_valid  in  1  fetch request
if_req_ready  out  1  fetch request accepted this cycle
if_req_addr  in  ADDR_W  fetch address
if_rsp_valid  out  1  fetch response strobe, 1 cycle
d_req_valid  in  1  data request
d_req_ready  out  1  data request accepted this cycle
d_req_we  in  1  1=store, 0=load
d_req_be  in  4  byte enables
d_req_addr  in  ADDR_W  data address
d_req_wdata  in  32  store data
d_rsp_valid  out  1  data response strobe (loads and store acks), 1 cycle
rsp_rdata  out  32  response data, shared, valid with either rsp_valid
rsp_err  out  1  response error, shared, valid with either rsp_valid
mem_req_valid  out  1  memory request
mem_req_ready  in  1  memory accepts request
mem_req_we / mem_req_be / mem_req_addr / mem_req_wdata  out  1/4/ADDR_W/32  latched request fields
mem_rsp_valid  in  1  memory response, earliest the cycle after acceptance
mem_rsp_rdata  in  32  memory read data

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, streak counter 0, owner cleared. All outputs 0.
- States: IDLE -> REQ -> WAIT -> IDLE.
- IDLE, grant rule:
  - Only one valid: grant it.
  - Both valid: grant data unless streak==STARVE_LIMIT; then grant fetch.
  - Grant is signalled by the winner's *_req_ready=1 combinationally in that cycle (handshake = valid&ready).
  - On handshake: latch addr/we/be/wdata and owner. Fetch latches we=0, be=4'b1111, wdata=0. Go to REQ.
- Streak counter:
  - Data grant while if_req_valid=1: +1, saturating at STARVE_LIMIT.
  - Any fetch grant: clears to 0.
  - Data grant with if_req_valid=0: clears to 0.
- REQ: mem_req_valid=1, fields held stable. On mem_req_ready=1 go to WAIT. No *_req_ready in REQ or WAIT.
- WAIT: on mem_rsp_valid=1:
  - Owner's rsp_valid=1 for that cycle (combinational, same cycle).
  - rsp_rdata=mem_rsp_rdata, rsp_err=0.
  - Go to IDLE.
- rsp_rdata=0 whenever neither rsp_valid is high.
- Minimum latency: handshake T; mem_req_valid T+1; response T+2 if memory is ready at T+1 and responds at T+2. Next grant earliest T+3.
- mem_rsp_valid in IDLE or REQ is ignored (stray).
- Reset mid-transaction: request abandoned, no response delivered. A late memory response after reset is ignored.
- Requester may drop valid before handshake without effect.

Optional Feature:
Macro ARB_TIMEOUT_EN.
- Defined: a counter runs in WAIT, cleared on entry.
  - When it reaches TIMEOUT_CYCLES with no mem_rsp_valid: owner rsp_valid=1, rsp_err=1, rsp_rdata=0; go to IDLE.
  - Response in the same cycle as expiry wins, with rsp_err=0.
- Undefined: no counter, WAIT indefinitely, rsp_err tied 0, TIMEOUT_CYCLES unused.

Test Plan:
- Fetch only: if_req addr 0x100, memory ready at once, responds 0xDEADBEEF next cycle -> mem_req addr=0x100 we=0 be=1111; if_rsp_valid 1 cycle with rsp_rdata=0xDEADBEEF at T+2.
- Simultaneous valid, streak 0 -> d_req_ready first; fetch granted at the next IDLE after the data response.
- STARVE_LIMIT=2, both held valid continuously, single-cycle memory -> grant order D,D,I,D,D,I.
- Store addr 0x204 be=0011 wdata 0x12345678, mem_req_ready low 3 cycles -> mem_req_valid and fields stable 4 cycles; d_rsp_valid on ack; no if_rsp_valid.
- Reset pulsed in WAIT, memory responds 2 cycles later -> all outputs 0, no rsp_valid; next fetch completes normally.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, memory never responds -> owner rsp_valid with rsp_err=1 after 8 WAIT cycles; state returns to IDLE.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals around mem_port_arbiter.
// slave is the arbiter's view; master is the view of the core and memory around it.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32
) ();
    logic              if_req_valid;
    logic              if_req_ready;
    logic [ADDR_W-1:0] if_req_addr;
    logic              if_rsp_valid;

    logic              d_req_valid;
    logic              d_req_ready;
    logic              d_req_we;
    logic [3:0]        d_req_be;
    logic [ADDR_W-1:0] d_req_addr;
    logic [31:0]       d_req_wdata;
    logic              d_rsp_valid;

    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_we;
    logic [3:0]        mem_req_be;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [31:0]       mem_req_wdata;
    logic              mem_rsp_valid;
    logic [31:0]       mem_rsp_rdata;

    modport slave (
        input  if_req_valid, if_req_addr,
        input  d_req_valid, d_req_we, d_req_be, d_req_addr, d_req_wdata,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
        output if_req_ready, if_rsp_valid, d_req_ready, d_rsp_valid,
        output rsp_rdata, rsp_err,
        output mem_req_valid, mem_req_we, mem_req_be, mem_req_addr, mem_req_wdata
    );

    modport master (
        output if_req_valid, if_req_addr,
        output d_req_valid, d_req_we, d_req_be, d_req_addr, d_req_wdata,
        output mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
        input  if_req_ready, if_rsp_valid, d_req_ready, d_rsp_valid,
        input  rsp_rdata, rsp_err,
        input  mem_req_valid, mem_req_we, mem_req_be, mem_req_addr, mem_req_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch and load/store.
// Optional response watchdog is compiled in with `define ARB_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_port_arbiter_if.slave    bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [3:0]        streak_reg, streak_next;
    logic              owner_reg, owner_next;      // 1 = data requester owns the transaction
    logic              we_reg, we_next;
    logic [3:0]        be_reg, be_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [31:0]       wdata_reg, wdata_next;

    logic grant_d;
    logic grant_i;
    logic rsp_fire;
    logic timeout_expire;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            streak_reg <= '0;
            owner_reg  <= 1'b0;
            we_reg     <= 1'b0;
            be_reg     <= '0;
            addr_reg   <= '0;
            wdata_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            streak_reg <= streak_next;
            owner_reg  <= owner_next;
            we_reg     <= we_next;
            be_reg     <= be_next;
            addr_reg   <= addr_next;
            wdata_reg  <= wdata_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        streak_next = streak_reg;
        owner_next  = owner_reg;
        we_next     = we_reg;
        be_next     = be_reg;
        addr_next   = addr_reg;
        wdata_next  = wdata_reg;
        grant_d     = 1'b0;
        grant_i     = 1'b0;
        rsp_fire    = 1'b0;

        case (state_reg)
            IDLE: begin
                // Data wins unless fetch has already waited through STARVE_LIMIT data grants.
                if (bus.d_req_valid &&
                    !(bus.if_req_valid && (streak_reg == 4'(STARVE_LIMIT)))) begin
                    grant_d = 1'b1;
                end else if (bus.if_req_valid) begin
                    grant_i = 1'b1;
                end

                if (grant_d) begin
                    owner_next = 1'b1;
                    we_next    = bus.d_req_we;
                    be_next    = bus.d_req_be;
                    addr_next  = bus.d_req_addr;
                    wdata_next = bus.d_req_wdata;
                    state_next = REQ;
                    if (!bus.if_req_valid) begin
                        streak_next = '0;
                    end else if (streak_reg != 4'(STARVE_LIMIT)) begin
                        streak_next = streak_reg + 4'd1;
                    end
                end else if (grant_i) begin
                    owner_next  = 1'b0;
                    we_next     = 1'b0;
                    be_next     = 4'b1111;
                    addr_next   = bus.if_req_addr;
                    wdata_next  = '0;
                    streak_next = '0;
                    state_next  = REQ;
                end
            end
            REQ: begin
                if (bus.mem_req_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (bus.mem_rsp_valid || timeout_expire) begin
                    rsp_fire   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_reg;

    // Counts cycles spent in WAIT; held at zero everywhere else so each wait starts fresh.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt_reg <= '0;
        end else if (state_reg != WAIT) begin
            to_cnt_reg <= '0;
        end else begin
            to_cnt_reg <= to_cnt_reg + TO_W'(1);
        end
    end

    assign timeout_expire = (state_reg == WAIT) &&
                            (to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));
`else
    // Watchdog compiled out: the wait for a response is unbounded.
    assign timeout_expire = (TIMEOUT_CYCLES < 0);
`endif

    // Readies are gated by reset so nothing is granted while reset is held.
    assign bus.d_req_ready   = grant_d & reset;
    assign bus.if_req_ready  = grant_i & reset;

    assign bus.mem_req_valid = (state_reg == REQ);
    assign bus.mem_req_we    = we_reg;
    assign bus.mem_req_be    = be_reg;
    assign bus.mem_req_addr  = addr_reg;
    assign bus.mem_req_wdata = wdata_reg;

    // A real response takes priority over a simultaneous timeout.
    assign bus.if_rsp_valid  = rsp_fire & ~owner_reg;
    assign bus.d_rsp_valid   = rsp_fire & owner_reg;
    assign bus.rsp_rdata     = (rsp_fire && bus.mem_rsp_valid) ? bus.mem_rsp_rdata : 32'h0;
    assign bus.rsp_err       = rsp_fire & ~bus.mem_rsp_valid;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a transaction-level model.
// Build with +define+ARB_TIMEOUT_EN to include the watchdog scenario.
module tb_mem_port_arbiter;
    localparam int ADDR_W         = 32;
    localparam int STARVE_LIMIT   = 2;
    localparam int TIMEOUT_CYCLES = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    mem_port_arbiter #(
        .ADDR_W        (ADDR_W),
        .STARVE_LIMIT  (STARVE_LIMIT),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: port is free, request offered to memory, or awaiting the response.
    int          phase;
    int          streak;
    int          waited;
    int          n_txn;
    logic        t_data;
    logic        t_we;
    logic [3:0]  t_be;
    logic [31:0] t_addr;
    logic [31:0] t_wdata;

    logic [1:0]  obs_ready;
    logic        obs_mv;
    logic [68:0] obs_fields;
    logic [2:0]  obs_rsp;
    logic [31:0] obs_rdata;
    logic [63:0] obs_gseq;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [31:0] ia,
                         input logic dv, input logic dwe, input logic [3:0] dbe,
                         input logic [31:0] da, input logic [31:0] dwd,
                         input logic mr, input logic mv, input logic [31:0] mrd);
        bus.if_req_valid  = iv;
        bus.if_req_addr   = ia;
        bus.d_req_valid   = dv;
        bus.d_req_we      = dwe;
        bus.d_req_be      = dbe;
        bus.d_req_addr    = da;
        bus.d_req_wdata   = dwd;
        bus.mem_req_ready = mr;
        bus.mem_rsp_valid = mv;
        bus.mem_rsp_rdata = mrd;
    endtask

    // One clock: sample at the falling edge, compare with the model, return at posedge+1.
    task automatic step();
        logic        exp_ir, exp_dr, exp_mv, exp_if, exp_d, exp_err;
        logic [31:0] exp_rdata;
        logic        take_d;
        @(negedge clk);
        obs_ready  = {bus.if_req_ready, bus.d_req_ready};
        obs_mv     = bus.mem_req_valid;
        obs_fields = {bus.mem_req_we, bus.mem_req_be, bus.mem_req_addr, bus.mem_req_wdata};
        obs_rsp    = {bus.if_rsp_valid, bus.d_rsp_valid, bus.rsp_err};
        obs_rdata  = bus.rsp_rdata;
        if (obs_ready == 2'b01) obs_gseq = {obs_gseq[62:0], 1'b1};
        else if (obs_ready == 2'b10) obs_gseq = {obs_gseq[62:0], 1'b0};

        exp_ir = 0; exp_dr = 0; exp_mv = 0; exp_if = 0; exp_d = 0; exp_err = 0;
        exp_rdata = 32'h0;
        if (phase == 0) begin
            take_d = bus.d_req_valid && !(bus.if_req_valid && streak == STARVE_LIMIT);
            if (take_d) begin
                exp_dr = 1; t_data = 1; t_we = bus.d_req_we; t_be = bus.d_req_be;
                t_addr = bus.d_req_addr; t_wdata = bus.d_req_wdata;
                streak = bus.if_req_valid ? ((streak < STARVE_LIMIT) ? streak + 1 : streak) : 0;
                phase = 1;
            end else if (bus.if_req_valid) begin
                exp_ir = 1; t_data = 0; t_we = 0; t_be = 4'hF;
                t_addr = bus.if_req_addr; t_wdata = 32'h0;
                streak = 0;
                phase = 1;
            end
        end else if (phase == 1) begin
            exp_mv = 1;
            if (bus.mem_req_ready) begin
                phase = 2;
                waited = 0;
            end
        end else begin
            waited++;
            if (bus.mem_rsp_valid) begin
                exp_if = !t_data; exp_d = t_data; exp_rdata = bus.mem_rsp_rdata;
                phase = 0;
                n_txn++;
                $display("txn %0d owner=%s we=%0d addr=%h rdata=%h err=0", n_txn,
                         t_data ? "D" : "I", t_we, t_addr, exp_rdata);
            end
`ifdef ARB_TIMEOUT_EN
            else if (waited == TIMEOUT_CYCLES) begin
                exp_if = !t_data; exp_d = t_data; exp_err = 1;
                phase = 0;
                n_txn++;
                $display("txn %0d owner=%s we=%0d addr=%h timeout err=1", n_txn,
                         t_data ? "D" : "I", t_we, t_addr);
            end
`endif
        end

        check_eq("ready", obs_ready, {exp_ir, exp_dr});
        check_eq("mem_valid", obs_mv, exp_mv);
        if (exp_mv) check_eq("mem_fields", obs_fields, {t_we, t_be, t_addr, t_wdata});
        check_eq("rsp_flags", obs_rsp, {exp_if, exp_d, exp_err});
        check_eq("rsp_rdata", obs_rdata, exp_rdata);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        drive(1, 32'hFFFF_FFFF, 1, 1, 4'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1, 32'hFFFF_FFFF);
        repeat (2) begin
            @(negedge clk);
            check_eq("reset_outs",
                     {bus.if_req_ready, bus.d_req_ready, bus.if_rsp_valid, bus.d_rsp_valid,
                      bus.rsp_err, bus.mem_req_valid, bus.mem_req_we, bus.mem_req_be,
                      bus.mem_req_addr, bus.mem_req_wdata, bus.rsp_rdata}, 128'h0);
            @(posedge clk);
            #1;
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset  = 1'b1;
        phase  = 0;
        streak = 0;
        waited = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int cnt;
        phase = 0; streak = 0; waited = 0; n_txn = 0;
        t_data = 0; t_we = 0; t_be = 0; t_addr = 0; t_wdata = 0;
        obs_gseq = 64'h1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        apply_reset();

        // Fetch only, fastest memory.
        drive(1, 32'h100, 0, 0, 0, 0, 0, 1, 0, 0);
        step(); check_eq("fetch_grant", obs_ready, 2'b10);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(); check_eq("fetch_req", {obs_mv, obs_fields}, {1'b1, 1'b0, 4'hF, 32'h100, 32'h0});
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'hDEAD_BEEF);
        step(); check_eq("fetch_rsp", {obs_rsp, obs_rdata}, {3'b100, 32'hDEAD_BEEF});

        // Simultaneous requests with streak 0: data first, fetch next.
        drive(1, 32'h300, 1, 0, 4'hF, 32'h400, 0, 1, 0, 0);
        step(); check_eq("both_data_first", obs_ready, 2'b01);
        drive(1, 32'h300, 0, 0, 0, 0, 0, 1, 0, 0);
        step();
        drive(1, 32'h300, 0, 0, 0, 0, 0, 1, 1, 32'h55);
        step(); check_eq("data_rsp", obs_rsp, 3'b010);
        drive(1, 32'h300, 0, 0, 0, 0, 0, 1, 0, 0);
        step(); check_eq("then_fetch", obs_ready, 2'b10);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h66);
        step();

        // Starvation limit: both held valid, single-cycle memory.
        apply_reset();
        obs_gseq = 64'h1;
        drive(1, 32'h700, 1, 0, 4'hF, 32'h800, 0, 1, 1, 32'hA5A5_A5A5);
        repeat (18) step();
        check_eq("grant_order_DDIDDI", obs_gseq, 64'b1110110);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();

        // Store held by a stalled memory.
        drive(0, 0, 1, 1, 4'b0011, 32'h204, 32'h1234_5678, 0, 0, 0);
        step(); check_eq("store_grant", obs_ready, 2'b01);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) begin
            step();
            check_eq("store_hold", {obs_mv, obs_fields}, {1'b1, 1'b1, 4'b0011, 32'h204, 32'h1234_5678});
        end
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(); check_eq("store_accept", {obs_mv, obs_fields}, {1'b1, 1'b1, 4'b0011, 32'h204, 32'h1234_5678});
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hCAFE_0001);
        step(); check_eq("store_ack", obs_rsp, 3'b010);

        // Reset while waiting; the late response must vanish.
        drive(1, 32'h500, 0, 0, 0, 0, 0, 1, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step();
        apply_reset();
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0BAD);
        step(); check_eq("late_rsp_ignored", obs_rsp, 3'b000);
        drive(1, 32'h600, 0, 0, 0, 0, 0, 1, 0, 0);
        step(); check_eq("post_reset_grant", obs_ready, 2'b10);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h77);
        step(); check_eq("post_reset_fetch", {obs_rsp, obs_rdata}, {3'b100, 32'h77});

`ifdef ARB_TIMEOUT_EN
        // Memory never answers: watchdog response after TIMEOUT_CYCLES wait cycles.
        drive(0, 0, 1, 0, 4'hF, 32'h900, 0, 1, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cnt = 0;
        while (cnt < 40) begin
            step();
            cnt++;
            if (obs_rsp != 3'b000) break;
        end
        check_eq("timeout_cycles", cnt, TIMEOUT_CYCLES);
        check_eq("timeout_rsp", {obs_rsp, obs_rdata}, {3'b011, 32'h0});
        drive(1, 32'hA00, 0, 0, 0, 0, 0, 0, 0, 0);
        step(); check_eq("idle_after_timeout", obs_ready, 2'b10);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h88);
        step();
`else
        cnt = 0;
`endif

        // Randomized traffic including stray responses and dropped valids.
        repeat (800) begin
            drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 4'($urandom), $urandom, $urandom,
                  1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), $urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
